// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file sizing, the port-1 kill cause and lane slicing.
package rf_pkg;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_XLEN = 32;
  localparam int RF_LANES = 2;
  localparam logic [2:0] MCAUSE_KILL_WR1 = 3'd6;
  function automatic int laneBase(input int lane, input int xlen);
    return lane * xlen;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bits with set/clear/flush and hazard lookup for three read ports.
module rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AW = $clog2(NUM_REGS),
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic setEn,
  input  logic [AW-1:0] setAddr,
  input  logic flush,
  input  logic clrEn1,
  input  logic [AW-1:0] clrAddr1,
  input  logic clrEn2,
  input  logic [AW-1:0] clrAddr2,
  input  logic [2:0][AW-1:0] rdAddr,
  output logic [2:0] busy
);
  logic [NUM_REGS-1:0] pending, pendingNxt;
  // a new issue outranks a retiring write to the same register
  always_comb begin
    pendingNxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      pendingNxt[i] = (setEn && setAddr != '0 && setAddr == AW'(i)) ||
                      (!flush && pending[i] && !(clrEn1 && clrAddr1 == AW'(i)) && !(clrEn2 && clrAddr2 == AW'(i)));
  end
  always_comb begin
    busy = '0;
    for (int p = 0; p < 3; p++)
      busy[p] = pending[rdAddr[p]] && !(BYPASS != 0 && ((clrEn1 && clrAddr1 == rdAddr[p]) || (clrEn2 && clrAddr2 == rdAddr[p])));
  end
  always_ff @(posedge clk)
    if (!rst_n) pending <= '0;
    else pending <= pendingNxt;
endmodule

// File: rtl/simd_regfile_sb.sv
// simd_regfile_sb: dual-write LANES x XLEN register file with per-lane masks, optional bypass and a pending-write scoreboard.
import rf_pkg::*;
module simd_regfile_sb #(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int XLEN = RF_XLEN,
  parameter int LANES = RF_LANES,
  parameter int BYPASS = 1,
  parameter int AW = $clog2(NUM_REGS),
  parameter int LW = $clog2(LANES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [2:0] csr_mcause,
  input  logic csr_excp_flag,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  input  logic [AW-1:0] rd_addr3,
  input  logic rd_simd,
  input  logic [LW-1:0] rd_lane,
  output logic [LANES*XLEN-1:0] rd_data1,
  output logic [LANES*XLEN-1:0] rd_data2,
  output logic [LANES*XLEN-1:0] rd_data3,
  output logic rd_busy1,
  output logic rd_busy2,
  output logic rd_busy3,
  input  logic wr_en1,
  input  logic wr_en2,
  input  logic [AW-1:0] wr_addr1,
  input  logic [AW-1:0] wr_addr2,
  input  logic [LANES-1:0] wr_mask1,
  input  logic [LANES-1:0] wr_mask2,
  input  logic [LANES*XLEN-1:0] wr_data1,
  input  logic [LANES*XLEN-1:0] wr_data2,
  input  logic sb_set_en,
  input  logic [AW-1:0] sb_set_addr,
  input  logic sb_flush
);
  logic we1, we2;
  logic [XLEN-1:0] mem [NUM_REGS][LANES];
  logic [AW-1:0] rdAddr [3];
  logic [LANES-1:0][XLEN-1:0] laneVal [3];
  logic [LANES*XLEN-1:0] rdOut [3];
  assign we1 = wr_en1 && !(csr_excp_flag && csr_mcause == MCAUSE_KILL_WR1);
  assign we2 = wr_en2;
  assign rdAddr = '{rd_addr1, rd_addr2, rd_addr3};
  // port 1 is assigned last so it owns any lane both ports hit
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int a = 0; a < NUM_REGS; a++)
        for (int k = 0; k < LANES; k++) mem[a][k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (we2 && wr_addr2 != '0 && wr_mask2[k]) mem[wr_addr2][k] <= wr_data2[laneBase(k, XLEN) +: XLEN];
        if (we1 && wr_addr1 != '0 && wr_mask1[k]) mem[wr_addr1][k] <= wr_data1[laneBase(k, XLEN) +: XLEN];
      end
    end
  for (genvar p = 0; p < 3; p++) begin : g_rd
    for (genvar k = 0; k < LANES; k++) begin : g_ln
      logic h1, h2;
      assign h1 = BYPASS != 0 && we1 && wr_addr1 == rdAddr[p] && wr_mask1[k];
      assign h2 = BYPASS != 0 && we2 && wr_addr2 == rdAddr[p] && wr_mask2[k];
      assign laneVal[p][k] = h1 ? wr_data1[laneBase(k, XLEN) +: XLEN] :
                             h2 ? wr_data2[laneBase(k, XLEN) +: XLEN] : mem[rdAddr[p]][k];
    end
    assign rdOut[p] = rdAddr[p] == '0 ? '0 :
                      rd_simd ? laneVal[p] : {{((LANES-1)*XLEN){1'b0}}, laneVal[p][rd_lane]};
  end
  assign rd_data1 = rdOut[0];
  assign rd_data2 = rdOut[1];
  assign rd_data3 = rdOut[2];
  rf_scoreboard #(.NUM_REGS(NUM_REGS), .AW(AW), .BYPASS(BYPASS)) uSb (
    .clk(clk),
    .rst_n(rst_n),
    .setEn(sb_set_en),
    .setAddr(sb_set_addr),
    .flush(sb_flush),
    .clrEn1(we1),
    .clrAddr1(wr_addr1),
    .clrEn2(we2),
    .clrAddr2(wr_addr2),
    .rdAddr({rd_addr3, rd_addr2, rd_addr1}),
    .busy({rd_busy3, rd_busy2, rd_busy1})
  );
endmodule

// File: tb/tb_simd_regfile_sb.sv
// tb_simd_regfile_sb: directed vectors against a bypassing and a non-bypassing instance.
module tb_simd_regfile_sb;
  logic clk = 0, rst_n = 0;
  logic [2:0] csr_mcause = 0;
  logic csr_excp_flag = 0;
  logic [4:0] rd_addr1 = 0, rd_addr2 = 0, rd_addr3 = 0;
  logic rd_simd = 1;
  logic rd_lane = 0;
  logic wr_en1 = 0, wr_en2 = 0;
  logic [4:0] wr_addr1 = 0, wr_addr2 = 0;
  logic [1:0] wr_mask1 = 0, wr_mask2 = 0;
  logic [63:0] wr_data1 = 0, wr_data2 = 0;
  logic sb_set_en = 0, sb_flush = 0;
  logic [4:0] sb_set_addr = 0;
  logic [63:0] bData1, bData2, bData3, nData1, nData2, nData3;
  logic bBusy1, bBusy2, bBusy3, nBusy1, nBusy2, nBusy3;
  int nVec = 0, nBad = 0;

  always #5 clk = ~clk;

  simd_regfile_sb #(.BYPASS(1)) dutB (
    .clk(clk), .rst_n(rst_n), .csr_mcause(csr_mcause), .csr_excp_flag(csr_excp_flag),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3), .rd_simd(rd_simd), .rd_lane(rd_lane),
    .rd_data1(bData1), .rd_data2(bData2), .rd_data3(bData3),
    .rd_busy1(bBusy1), .rd_busy2(bBusy2), .rd_busy3(bBusy3),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_mask1(wr_mask1), .wr_mask2(wr_mask2), .wr_data1(wr_data1), .wr_data2(wr_data2),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush));

  simd_regfile_sb #(.BYPASS(0)) dutN (
    .clk(clk), .rst_n(rst_n), .csr_mcause(csr_mcause), .csr_excp_flag(csr_excp_flag),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3), .rd_simd(rd_simd), .rd_lane(rd_lane),
    .rd_data1(nData1), .rd_data2(nData2), .rd_data3(nData3),
    .rd_busy1(nBusy1), .rd_busy2(nBusy2), .rd_busy3(nBusy3),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_mask1(wr_mask1), .wr_mask2(wr_mask2), .wr_data1(wr_data1), .wr_data2(wr_data2),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en1 = 0; wr_en2 = 0; wr_mask1 = 0; wr_mask2 = 0;
    sb_set_en = 0; sb_flush = 0; csr_excp_flag = 0; csr_mcause = 0;
  endtask

  initial begin
    rd_addr1 = 5; rd_addr2 = 0; rd_addr3 = 31;
    step(); step();
    #1;
    chk("rst_d1", bData1, 64'h0);
    chk("rst_d3", bData3, 64'h0);
    chk("rst_busy", {61'h0, bBusy1, bBusy2, bBusy3}, 64'h0);
    rst_n = 1;

    wr_en1 = 1; wr_addr1 = 0; wr_mask1 = 2'b11; wr_data1 = '1; rd_addr2 = 0;
    #1 chk("x0_bypass", bData2, 64'h0);
    step(); idle();
    #1 chk("x0_read", bData2, 64'h0);

    wr_en1 = 1; wr_addr1 = 5; wr_mask1 = 2'b11; wr_data1 = {32'hAAAA_0001, 32'h5555_0002};
    step(); idle();
    rd_addr1 = 5; rd_simd = 1;
    #1 chk("simd_full", bData1, 64'hAAAA_0001_5555_0002);
    rd_simd = 0; rd_lane = 1;
    #1 chk("scalar_l1", bData1, 64'h0000_0000_AAAA_0001);
    rd_lane = 0;
    #1 chk("scalar_l0", nData1, 64'h0000_0000_5555_0002);
    rd_simd = 1;

    wr_en1 = 1; wr_addr1 = 7; wr_mask1 = 2'b01; wr_data1 = {32'h99, 32'h11};
    wr_en2 = 1; wr_addr2 = 7; wr_mask2 = 2'b11; wr_data2 = {32'h22, 32'h33};
    rd_addr3 = 7;
    #1 chk("conf_bypass", bData3, {32'h22, 32'h11});
    chk("conf_nobyp", nData3, 64'h0);
    step(); idle();
    #1 chk("conf_commit", nData3, {32'h22, 32'h11});

    sb_set_en = 1; sb_set_addr = 9;
    step(); idle();
    wr_en1 = 1; wr_addr1 = 9; wr_mask1 = 2'b11; wr_data1 = {32'h1, 32'h2};
    csr_mcause = 6; csr_excp_flag = 1; rd_addr1 = 9;
    #1 chk("kill_busy_now", {63'h0, bBusy1}, 64'h1);
    chk("kill_data_now", bData1, 64'h0);
    step();
    #1 chk("kill_data", nData1, 64'h0);
    chk("kill_pending", {63'h0, nBusy1}, 64'h1);
    csr_mcause = 5;
    #1 chk("cause5_byp_busy", {63'h0, bBusy1}, 64'h0);
    chk("cause5_nb_busy", {63'h0, nBusy1}, 64'h1);
    step(); idle();
    #1 chk("cause5_data", bData1, {32'h1, 32'h2});
    chk("cause5_busy", {62'h0, bBusy1, nBusy1}, 64'h0);

    wr_en1 = 1; wr_addr1 = 3; wr_mask1 = 2'b11; wr_data1 = {32'h77, 32'h66};
    sb_set_en = 1; sb_set_addr = 3;
    step(); idle();
    rd_addr2 = 3;
    #1 chk("set_wins_wr", {62'h0, bBusy2, nBusy2}, 64'h3);
    wr_en1 = 1; wr_addr1 = 3; wr_mask1 = 2'b01; wr_data1 = {32'h0, 32'hDEAD};
    rd_simd = 0; rd_lane = 0;
    #1 chk("byp_data", bData2, 64'hDEAD);
    chk("byp_busy", {63'h0, bBusy2}, 64'h0);
    chk("nobyp_data", nData2, 64'h66);
    chk("nobyp_busy", {63'h0, nBusy2}, 64'h1);
    step(); idle(); rd_simd = 1;
    #1 chk("byp_commit", nData2, {32'h77, 32'hDEAD});

    sb_set_en = 1; sb_set_addr = 4; rd_addr1 = 4;
    step(); idle();
    #1 chk("sb_set4", {63'h0, bBusy1}, 64'h1);
    sb_set_en = 1; sb_set_addr = 4; wr_en2 = 1; wr_addr2 = 4; wr_mask2 = 2'b00;
    step(); idle();
    #1 chk("sb_setclr4", {62'h0, bBusy1, nBusy1}, 64'h3);
    wr_en2 = 1; wr_addr2 = 4; wr_mask2 = 2'b00;
    step(); idle();
    #1 chk("sb_clr4", {62'h0, bBusy1, nBusy1}, 64'h0);
    chk("mask0_data", bData1, 64'h0);
    sb_set_en = 1; sb_set_addr = 4;
    step();
    sb_set_addr = 8;
    step(); idle();
    sb_flush = 1; sb_set_en = 1; sb_set_addr = 6;
    step(); idle();
    rd_addr1 = 4; rd_addr2 = 6; rd_addr3 = 8;
    #1 chk("flush", {61'h0, bBusy1, bBusy2, bBusy3}, 64'h2);

    rst_n = 0; wr_en1 = 1; wr_addr1 = 5; wr_mask1 = 2'b11; wr_data1 = 64'h1234;
    sb_set_en = 1; sb_set_addr = 10;
    step(); idle(); rst_n = 1;
    rd_addr1 = 5; rd_addr3 = 10;
    #1 chk("mid_rst_data", bData1, 64'h0);
    chk("mid_rst_busy", {61'h0, bBusy1, bBusy2, bBusy3}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule

// File: doc/simd_regfile_sb.md
Name: simd_regfile_sb

Overview:
- Parametrised successor to the core's dual-write SIMD register file.
- Generalised to LANES x XLEN per architectural register, with per-lane write masks, per-lane conflict resolution between the two write ports, and an optional same-cycle write-to-read bypass.
- Adds a pending-write scoreboard, so the decode/issue stage reads operands and hazard status from one block.
- Sits between decode (read and scoreboard set) and the two writeback paths (ALU/SIMD on port 1, LSU on port 2).

Parameters:
- NUM_REGS, 32, architectural register count; x0 is hardwired zero.
- XLEN, 32, width of one lane.
- LANES, 2, lanes per register; must be a power of two, at least 2.
- BYPASS, 1, when 1 same-cycle writes are forwarded to the read ports.
- AW, $clog2(NUM_REGS), address width (derived).
- LW, $clog2(LANES), lane index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- csr_mcause  in  3  exception cause, low bits.
- csr_excp_flag  in  1  exception taken this cycle.
- rd_addr1/2/3  in  AW  read addresses.
- rd_simd  in  1  1 = return all lanes on every read port.
- rd_lane  in  LW  lane returned when rd_simd=0.
- rd_data1/2/3  out  LANES*XLEN  read data.
- rd_busy1/2/3  out  1  register has a write outstanding.
- wr_en1/2  in  1  write enables.
- wr_addr1/2  in  AW  write addresses.
- wr_mask1/2  in  LANES  per-lane write enables.
- wr_data1/2  in  LANES*XLEN  write data; lane k is bits [k*XLEN +: XLEN].
- sb_set_en  in  1  issue marks a destination pending.
- sb_set_addr  in  AW  destination being marked.
- sb_flush  in  1  clear all pending bits.

Behaviour:
- Reset (rst_n=0 at posedge): all register lanes and all pending bits go to 0. Reset wins over every other input.
- Storage is NUM_REGS x LANES words of XLEN bits.
- Reads are combinational, 0-cycle latency.
  - rd_simd=1: the full vector is returned.
  - rd_simd=0: lane rd_lane is returned in bits [XLEN-1:0]; all upper bits are 0.
  - Address 0 always returns 0, and its busy is 0.
- Port-1 kill: wr_en1 is suppressed when csr_mcause==6 and csr_excp_flag=1. A suppressed write neither writes storage nor clears pending.
- Writes commit at posedge.
  - Lane k of register a is written when the port's enable is 1, its addr==a, a!=0 and mask[k]=1.
  - Both ports hitting the same register and lane: port 1 wins.
  - Non-overlapping lanes of the same register from the two ports both commit.
  - Mask 0 is a no-op for storage but still clears pending.
- Bypass (BYPASS=1): for each read lane, an effective write to that register and lane in the same cycle is forwarded, using port-1 priority. Unmasked lanes come from storage. BYPASS=0: reads see the pre-write value.
- Scoreboard, pending[NUM_REGS]; all updates take effect at the next posedge.
  - Set: sb_set_en=1 and sb_set_addr!=0.
  - Clear: any effective write enable to that address, whatever the mask.
  - Set and clear on the same address in the same cycle: set wins, because the new producer has issued.
  - sb_flush=1: clears everything; a same-cycle sb_set still applies after the flush.
- rd_busyN = pending[rd_addrN] & ~(BYPASS & an effective write to rd_addrN this cycle).
- Both ports writing the same register with pending set clears it once; there is no error.
- No internal FSM beyond the storage and scoreboard registers. No multi-cycle operations, so reset mid-stream only requires the rule above.

Decomposition:
- Shared package rf_pkg: RF_NUM_REGS, RF_XLEN, RF_LANES, the MCAUSE_KILL_WR1=3'd6 constant, and a lane-slice helper function.
- One natural sub-module, rf_scoreboard: pending vector with set/clear/flush and busy lookup, instantiated once.
- Storage, write arbitration and bypass stay in the top level.

Test Plan:
1. Reset hold, then reads: with rst_n=0 for 2 cycles, all rd_data=0 and all rd_busy=0. Writing x0 with data all-ones and reading it back returns 0.
2. SIMD write, scalar read: port 1 writes x5 with mask=2'b11 and data {32'hAAAA_0001, 32'h5555_0002}.
   - rd_simd=1 returns the full 64-bit value.
   - rd_simd=0 with lane 1 returns {32'h0, 32'hAAAA_0001}.
3. Port conflict: both ports write x7, port1 mask=01 with 32'h11, port2 mask=11 with {32'h22, 32'h33}. Next cycle x7 = {32'h22, 32'h11}.
4. Kill: wr_en1 to x9 with csr_mcause=6 and csr_excp_flag=1 leaves x9 unchanged and pending[9] still set. With csr_mcause=5 the write commits.
5. Bypass: write x3=32'hDEAD, lane 0, while reading x3 in the same cycle. BYPASS=1 gives rd_data=32'hDEAD and busy=0; BYPASS=0 gives the old value.
6. Scoreboard:
   - sb_set x4, then rd_busy=1 the next cycle.
   - A same-cycle set and write to x4 leaves busy=1.
   - A write to x4 alone clears it.
   - sb_flush with sb_set x6 in the same cycle leaves only pending[6]=1.
